// File: rtl/vec_alu_pkg.sv
// Shared constants, opcodes, flag indices and FSM states
// for the sequenced vector ALU.
package vec_alu_pkg;
  localparam int ELEM_W  = 16;
  localparam int LANES   = 4;
  localparam int MAX_LEN = 16;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SET = 3'b111;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    WRITE,
    DONE
  } state_t;
endpackage

// File: rtl/vec_flag_reduce.sv
// Masked reduction of per-lane C/Z/N/V flags for one group.
// Z is ANDed (1 when no lane is valid), the rest are ORed.
module vec_flag_reduce #(
  parameter int LANES = 4
) (
  input  logic [4*LANES-1:0] flags,
  input  logic [LANES-1:0]   mask,
  input  logic               carry_en,
  output logic [3:0]         red
);
  import vec_alu_pkg::*;

  always_comb begin
    red = 4'b0;
    red[FLAG_Z] = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        red[FLAG_C] = red[FLAG_C] | (carry_en & flags[4*i+FLAG_C]);
        red[FLAG_Z] = red[FLAG_Z] & flags[4*i+FLAG_Z];
        red[FLAG_N] = red[FLAG_N] | flags[4*i+FLAG_N];
        red[FLAG_V] = red[FLAG_V] | flags[4*i+FLAG_V];
      end
    end
  end
endmodule

// File: rtl/vec_alu_seq.sv
// Sequencer driving external ALU lanes group by group:
// read operands, execute, write back, accumulate flags.
module vec_alu_seq #(
  parameter int LANES   = vec_alu_pkg::LANES,
  parameter int MAX_LEN = vec_alu_pkg::MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_opcode,
  input  logic                  req_scalar,
  input  logic [4:0]            req_len,
  output logic                  rd_en,
  output logic [1:0]            rd_addr,
  input  logic [16*LANES-1:0]   rd_data_a,
  input  logic [16*LANES-1:0]   rd_data_b,
  input  logic [16*LANES-1:0]   rd_data_c,
  output logic [16*LANES-1:0]   alu_a,
  output logic [16*LANES-1:0]   alu_b,
  output logic [16*LANES-1:0]   alu_c,
  output logic [2:0]            alu_opcode,
  output logic                  alu_scalar,
  input  logic [16*LANES-1:0]   alu_res,
  input  logic [4*LANES-1:0]    alu_flags,
  output logic                  wr_en,
  output logic [1:0]            wr_addr,
  output logic [16*LANES-1:0]   wr_data,
  output logic [LANES-1:0]      wr_mask,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            flags_out
);
  import vec_alu_pkg::*;

  state_t           state;
  logic [4:0]       len_q;
  logic [5:0]       base;
  logic [1:0]       grp;
  logic [3:0]       acc;
  logic [3:0]       red;
  logic [3:0]       acc_next;
  logic [4:0]       eff_len;
  logic [LANES-1:0] lane_mask;
  logic             last;
  logic [16*LANES-1:0] opa, opb, opc;

  assign alu_a   = opa;
  assign alu_b   = opb;
  assign alu_c   = opc;
  assign wr_data = alu_res;

  always_comb begin
    eff_len = req_len;
    if (req_scalar)
      eff_len = 5'd1;
    else if (int'(req_len) > MAX_LEN)
      eff_len = 5'(MAX_LEN);
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < LANES; i++)
      lane_mask[i] = (int'(base) + i) < int'(len_q);
  end

  assign last = (int'(base) + LANES) >= int'(len_q);

  vec_flag_reduce #(
    .LANES(LANES)
  ) u_reduce (
    .flags   (alu_flags),
    .mask    (wr_mask),
    .carry_en(alu_opcode != OP_MUL),
    .red     (red)
  );

  always_comb begin
    acc_next = acc | red;
    acc_next[FLAG_Z] = acc[FLAG_Z] & red[FLAG_Z];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      wr_mask    <= '0;
      rd_addr    <= '0;
      wr_addr    <= '0;
      opa        <= '0;
      opb        <= '0;
      opc        <= '0;
      alu_opcode <= '0;
      alu_scalar <= 1'b0;
      flags_out  <= '0;
      len_q      <= '0;
      base       <= '0;
      grp        <= '0;
      acc        <= 4'b0010;
    end else begin
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      wr_mask <= '0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_scalar <= req_scalar;
            len_q      <= eff_len;
            base       <= '0;
            grp        <= '0;
            acc        <= 4'b0010;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            if (eff_len == 5'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              flags_out <= '0;
            end else begin
              state   <= READ;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          opa     <= rd_data_a;
          opb     <= rd_data_b;
          opc     <= rd_data_c;
          state   <= WRITE;
          wr_en   <= 1'b1;
          wr_addr <= grp;
          wr_mask <= lane_mask;
        end
        WRITE: begin
          acc <= acc_next;
          if (last) begin
            state     <= DONE;
            done      <= 1'b1;
            flags_out <= acc_next;
          end else begin
            // next group: advance element base with the group index
            grp     <= grp + 2'd1;
            base    <= base + 6'(LANES);
            rd_en   <= 1'b1;
            rd_addr <= grp + 2'd1;
            state   <= READ;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_alu_seq.sv
// Random and directed checks of vec_alu_seq against an
// element-level reference with a behavioural lane model.
module tb_vec_alu_seq;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_opcode = '0;
  logic          req_scalar = 1'b0;
  logic [4:0]    req_len = '0;
  logic          rd_en;
  logic [1:0]    rd_addr;
  logic [63:0]   rd_data_a = '0;
  logic [63:0]   rd_data_b = '0;
  logic [63:0]   rd_data_c = '0;
  logic [63:0]   alu_a, alu_b, alu_c;
  logic [2:0]    alu_opcode;
  logic          alu_scalar;
  logic [63:0]   alu_res;
  logic [15:0]   alu_flags;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [63:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          busy, done;
  logic [3:0]    flags_out;

  logic [63:0]   bank_a [4];
  logic [63:0]   bank_b [4];
  logic [63:0]   bank_c [4];
  logic [3:0]    prev_flags = '0;
  logic [19:0]   lt;
  int            checks = 0;
  int            errors = 0;

  vec_alu_seq #(.LANES(4), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_scalar(req_scalar),
    .req_len(req_len),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_data_c(rd_data_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_opcode(alu_opcode), .alu_scalar(alu_scalar),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy), .done(done), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  // lane: returns {V,N,Z,C,result}; MUL is signed Q8.8
  function automatic logic [19:0] lane_fn(
    input logic [2:0] op, input logic [15:0] a,
    input logic [15:0] b, input logic [15:0] c);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic cf, vf;
    w = '0; p = '0;
    case (op)
      3'b000: begin
        p  = $signed(a) * $signed(b);
        r  = p[23:8];
        cf = 1'b1;
        vf = !((p[31:23] == 9'h000) || (p[31:23] == 9'h1FF));
      end
      3'b001: begin
        w  = {1'b0, a} - {1'b0, b};
        r  = w[15:0];
        cf = (a >= b);
        vf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b010: begin
        w  = {1'b0, a} + {1'b0, b};
        r  = w[15:0];
        cf = w[16];
        vf = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b111: begin
        r = c; cf = 1'b0; vf = 1'b0;
      end
      default: begin
        r = a ^ b ^ c; cf = r[0]; vf = r[15] ^ r[14];
      end
    endcase
    return {vf, r[15], (r == 16'h0), cf, r};
  endfunction

  always_comb begin
    alu_res = '0;
    alu_flags = '0;
    lt = '0;
    for (int i = 0; i < LN; i++) begin
      lt = lane_fn(alu_opcode, alu_a[16*i+:16],
                   alu_b[16*i+:16], alu_c[16*i+:16]);
      alu_res[16*i+:16] = lt[15:0];
      alu_flags[4*i+:4] = lt[19:16];
    end
  end

  always @(posedge clk)
    if (rd_en) begin
      rd_data_a <= bank_a[rd_addr];
      rd_data_b <= bank_b[rd_addr];
      rd_data_c <= bank_c[rd_addr];
    end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_flags(input logic [2:0] op,
                                           input int len);
    logic cf, zf, nf, vf;
    logic [19:0] t;
    int g, l;
    cf = 0; zf = 1; nf = 0; vf = 0;
    if (len == 0) return 4'b0000;
    for (int e = 0; e < len; e++) begin
      g = e / LN; l = e % LN;
      t = lane_fn(op, bank_a[g][16*l+:16], bank_b[g][16*l+:16],
                  bank_c[g][16*l+:16]);
      cf |= t[16] && (op != 3'b000);
      zf &= t[17];
      nf |= t[18];
      vf |= t[19];
    end
    return {vf, nf, zf, cf};
  endfunction

  function automatic logic [63:0] ref_data(input logic [2:0] op,
                                           input int g);
    logic [63:0] d;
    logic [19:0] t;
    d = '0;
    for (int l = 0; l < LN; l++) begin
      t = lane_fn(op, bank_a[g][16*l+:16], bank_b[g][16*l+:16],
                  bank_c[g][16*l+:16]);
      d[16*l+:16] = t[15:0];
    end
    return d;
  endfunction

  task automatic rand_banks();
    for (int g = 0; g < 4; g++) begin
      bank_a[g] = {$urandom, $urandom};
      bank_b[g] = {$urandom, $urandom};
      bank_c[g] = {$urandom, $urandom};
    end
  endtask

  // called at a negedge with the DUT idle; returns at the
  // negedge one cycle after done
  task automatic run_op(input logic [2:0] op, input logic sc,
                        input logic [4:0] len);
    int L, G, dc, g;
    logic [3:0] ef, m;
    logic xr, xw, xd;
    L  = sc ? 1 : ((len > 16) ? 16 : int'(len));
    G  = (L + LN - 1) / LN;
    dc = (L == 0) ? 1 : 3 * G + 1;
    ef = ref_flags(op, L);
    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1; req_opcode = op; req_scalar = sc; req_len = len;
    @(negedge clk);
    for (int c = 1; c <= dc; c++) begin
      xr = (L > 0) && (c <= 3 * G - 2) && ((c - 1) % 3 == 0);
      xw = (L > 0) && (c >= 3) && (c <= 3 * G) && (c % 3 == 0);
      xd = (c == dc);
      chk($sformatf("strobes_c%0d", c), 64'({rd_en, wr_en, done}),
          64'({xr, xw, xd}));
      chk($sformatf("busy_c%0d", c), 64'({busy, req_ready}),
          64'(2'b10));
      if (xr)
        chk("rd_addr", 64'(rd_addr), 64'((c - 1) / 3));
      if (xw) begin
        g = c / 3 - 1;
        m = '0;
        for (int i = 0; i < LN; i++) m[i] = (g * LN + i < L);
        chk("wr_addr", 64'(wr_addr), 64'(g));
        chk("wr_mask", 64'(wr_mask), 64'(m));
        chk("wr_data", wr_data, ref_data(op, g));
        chk("alu_op", 64'({alu_opcode, alu_scalar}), 64'({op, sc}));
      end
      if (xd) begin
        chk("flags_done", 64'(flags_out), 64'(ef));
        req_valid = 0;
      end else begin
        chk("flags_hold", 64'(flags_out), 64'(prev_flags));
        req_valid = 1;
        req_opcode = 3'($urandom);
        req_scalar = 1'($urandom);
        req_len = 5'($urandom);
      end
      @(negedge clk);
    end
    chk("after_done", 64'({busy, req_ready, done, rd_en, wr_en}),
        64'(5'b01000));
    chk("flags_after", 64'(flags_out), 64'(ef));
    prev_flags = ef;
  endtask

  initial begin
    rand_banks();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({req_ready, busy, done, rd_en, wr_en}),
        64'(5'b10000));
    chk("rst_flags", 64'(flags_out), 64'd0);
    rst = 0;

    // ADD, L=4, constant operands
    for (int g = 0; g < 4; g++) begin
      bank_a[g] = {4{16'h0180}};
      bank_b[g] = {4{16'h0200}};
    end
    run_op(3'b010, 1'b0, 5'd4);
    chk("add4_data", ref_data(3'b010, 0), {4{16'h0380}});
    chk("add4_flags", 64'(flags_out), 64'(4'b0000));

    // ADD, L=6: two groups
    rand_banks();
    run_op(3'b010, 1'b0, 5'd6);

    // scalar MUL, req_len ignored
    rand_banks();
    bank_a[0][15:0] = 16'h0200;
    bank_b[0][15:0] = 16'hFE00;
    run_op(3'b000, 1'b1, 5'd9);
    chk("mul_flags", 64'(flags_out), 64'(4'b0100));

    // SUB signed overflow
    rand_banks();
    bank_a[0][15:0] = 16'h8000;
    bank_b[0][15:0] = 16'h0001;
    run_op(3'b001, 1'b0, 5'd1);
    chk("sub_flags", 64'(flags_out), 64'(4'b1001));

    // L=0
    run_op(3'b010, 1'b0, 5'd0);
    chk("len0_flags", 64'(flags_out), 64'd0);

    // length clamp to MAX_LEN
    rand_banks();
    run_op(3'b111, 1'b0, 5'd31);

    // reset during EXEC of group 0
    rand_banks();
    prev_flags = flags_out;
    req_valid = 1; req_opcode = 3'b010; req_scalar = 0; req_len = 8;
    @(negedge clk);
    req_valid = 0;
    chk("pre_rst_rd", 64'(rd_en), 64'd1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid_rst_ctrl", 64'({req_ready, busy, done, rd_en, wr_en}),
        64'(5'b10000));
    chk("mid_rst_addr", 64'({rd_addr, wr_addr, wr_mask}), 64'd0);
    chk("mid_rst_ops", alu_a | alu_b | alu_c, 64'd0);
    chk("mid_rst_misc", 64'({alu_opcode, alu_scalar, flags_out}),
        64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_nowr", 64'({wr_en, rd_en}), 64'd0);
    end
    rst = 0;
    prev_flags = '0;
    run_op(3'b010, 1'b0, 5'd8);

    // random mix
    for (int k = 0; k < 14; k++) begin
      rand_banks();
      run_op(3'($urandom), ($urandom_range(0, 3) == 0),
             5'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
